ej32_rsbr: RTL and testbench

- Parametrised return-stack and branching unit for the eJ32 Java Forth core; next generation of the branching unit.
- Holds the return stack (push/pop/move/local-load) with configurable depth and data width.
- Assembles 2-byte branch targets in absolute or PC-relative mode, resolves conditional, unconditional and donext branches.
- Adds overflow/underflow detection; driven by the decode FSM in place of the current branch unit.

---
 rtl/ej32_rsbr.sv | 181 ++++++++++++++++++
 tb/tb_ej32_rsbr.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ej32_rsbr.sv
// eJ32 return-stack and branching unit.
// Keeps the return stack as a registered top (r_o) plus an array of the
// entries below it, assembles two-byte branch offsets over two phases and
// resolves conditional, unconditional and donext (NEXT) branches.
//
// Handshake note: there is no valid/ready pairing here. Every enabled
// cycle consumes rs_cmd/br_cmd, and the two result strobes (ld_v, br_psel)
// are single-cycle pulses with no back-pressure; the consumer must sample
// them in the cycle they are high.
module ej32_rsbr #(
   parameter int DSZ   = 32,
   parameter int ASZ   = 17,
   parameter int DEPTH = 64,
   parameter int REL   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [2:0]               rs_cmd,
   input  logic [DSZ-1:0]           rs_d,
   input  logic [7:0]               rs_idx,
   input  logic [1:0]               br_cmd,
   input  logic                     br_cond,
   input  logic                     phase,
   input  logic [7:0]               data,
   input  logic [ASZ-1:0]           p,
   input  logic                     flag_clr,
   output logic [DSZ-1:0]           r_o,
   output logic                     rz_o,
   output logic [DSZ-1:0]           ld_o,
   output logic                     ld_v,
   output logic [ASZ-1:0]           br_p_o,
   output logic                     br_psel,
   output logic [$clog2(DEPTH):0]   rp_o,
   output logic                     ovf,
   output logic                     udf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int XW = CW + 8;
   localparam int TW = ASZ + 16;

   localparam logic [2:0] CMD_PUSH = 3'd1;
   localparam logic [2:0] CMD_POP  = 3'd2;
   localparam logic [2:0] CMD_MOVE = 3'd3;
   localparam logic [2:0] CMD_LOAD = 3'd4;
   localparam logic [2:0] CMD_NEXT = 3'd5;

   // Entries below the cached top; index 0 is the bottom of the stack.
   logic [DSZ-1:0] mem [0:DEPTH-2];
   logic [7:0]     hi;

   logic [DSZ-1:0] r_n, ld_n;
   logic [CW-1:0]  rp_n;
   logic           push_we, ovf_set, udf_set, ld_v_n, nx_taken, taken;
   logic [AW-1:0]  wr_idx, pop_idx, ld_idx;
   logic [XW-1:0]  rp_x, idx_x, ld_pos;
   logic [15:0]    off;
   logic [TW-1:0]  off_x, sum_x;
   logic [ASZ-1:0] target;

   assign rp_x    = XW'(rp_o);
   assign idx_x   = XW'(rs_idx);
   assign ld_pos  = rp_x - XW'(1) - idx_x;
   assign wr_idx  = AW'(rp_o - CW'(1));
   assign pop_idx = AW'(rp_o - CW'(2));
   assign ld_idx  = ld_pos[AW-1:0];

   // Branch target: the offset is {hi, data}; relative mode adds it sign-extended to p.
   assign off    = {hi, data};
   assign off_x  = (REL != 0) ? {{ASZ{off[15]}}, off} : {{ASZ{1'b0}}, off};
   assign sum_x  = (REL != 0) ? ({16'b0, p} + off_x) : off_x;
   assign target = sum_x[ASZ-1:0];

   // Stack command decode: next top, count, load result and error flags.
   always_comb begin
      r_n      = r_o;
      rp_n     = rp_o;
      ld_n     = ld_o;
      ld_v_n   = 1'b0;
      push_we  = 1'b0;
      ovf_set  = 1'b0;
      udf_set  = 1'b0;
      nx_taken = 1'b0;
      case (rs_cmd)
         CMD_PUSH: begin
            if (rp_o == CW'(DEPTH)) begin
               ovf_set = 1'b1;
            end else begin
               push_we = (rp_o != '0);
               r_n     = rs_d;
               rp_n    = rp_o + CW'(1);
            end
         end
         CMD_POP: begin
            if (rp_o == '0) begin
               udf_set = 1'b1;
            end else begin
               r_n  = (rp_o == CW'(1)) ? '0 : mem[pop_idx];
               rp_n = rp_o - CW'(1);
            end
         end
         CMD_MOVE: begin
            if (rp_o == '0) udf_set = 1'b1;
            else            r_n     = rs_d;
         end
         CMD_LOAD: begin
            ld_v_n = 1'b1;
            if (idx_x >= rp_x) begin
               ld_n    = '0;
               udf_set = 1'b1;
            end else if (rs_idx == 8'd0) begin
               ld_n = r_o;
            end else begin
               ld_n = mem[ld_idx];
            end
         end
         CMD_NEXT: begin
            // Only the resolving phase acts on the stack; rz_o mirrors r_o==0.
            if (phase) begin
               if (rp_o == '0) begin
                  udf_set = 1'b1;
               end else if (rz_o) begin
                  r_n  = (rp_o == CW'(1)) ? '0 : mem[pop_idx];
                  rp_n = rp_o - CW'(1);
               end else begin
                  r_n      = r_o - DSZ'(1);
                  nx_taken = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Branch decision; NEXT overrides any concurrent br_cmd.
   always_comb begin
      taken = 1'b0;
      if (phase) begin
         if (rs_cmd == CMD_NEXT) taken = nx_taken;
         else                    taken = (br_cmd == 2'd2) || ((br_cmd == 2'd1) && br_cond);
      end
   end

   // Registered state: stack top/count, strobes, branch target and sticky flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_o     <= '0;
         rz_o    <= 1'b1;
         ld_o    <= '0;
         ld_v    <= 1'b0;
         br_p_o  <= '0;
         br_psel <= 1'b0;
         rp_o    <= '0;
         ovf     <= 1'b0;
         udf     <= 1'b0;
         hi      <= '0;
      end else if (!en) begin
         ld_v    <= 1'b0;
         br_psel <= 1'b0;
      end else begin
         r_o     <= r_n;
         rz_o    <= (r_n == '0);
         rp_o    <= rp_n;
         ld_o    <= ld_n;
         ld_v    <= ld_v_n;
         br_psel <= taken;
         if (taken) br_p_o <= target;
         if (!phase && ((br_cmd != 2'd0) || (rs_cmd == CMD_NEXT))) hi <= data;
         ovf <= ovf_set | (ovf & ~flag_clr);
         udf <= udf_set | (udf & ~flag_clr);
      end
   end

   // Spill the old top into the array on a push; contents need no reset.
   always_ff @(posedge clk) begin
      if (en && push_we) mem[wr_idx] <= r_o;
   end

endmodule

// File: tb/tb_ej32_rsbr.sv
// Directed bench for ej32_rsbr. Two instances share all inputs: dut uses
// relative targets, dut0 absolute targets.
module tb_ej32_rsbr;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [2:0]  rs_cmd;
   logic [31:0] rs_d;
   logic [7:0]  rs_idx;
   logic [1:0]  br_cmd;
   logic        br_cond;
   logic        phase;
   logic [7:0]  data;
   logic [16:0] p;
   logic        flag_clr;

   logic [31:0] r_o, ld_o, r_o0, ld_o0;
   logic        rz_o, ld_v, br_psel, ovf, udf;
   logic        rz_o0, ld_v0, br_psel0, ovf0, udf0;
   logic [16:0] br_p_o, br_p_o0;
   logic [6:0]  rp_o, rp_o0;

   int tests = 0;
   int fails = 0;

   ej32_rsbr #(.DSZ(32), .ASZ(17), .DEPTH(64), .REL(1)) dut (
      .clk(clk), .rst(rst), .en(en), .rs_cmd(rs_cmd), .rs_d(rs_d), .rs_idx(rs_idx),
      .br_cmd(br_cmd), .br_cond(br_cond), .phase(phase), .data(data), .p(p),
      .flag_clr(flag_clr), .r_o(r_o), .rz_o(rz_o), .ld_o(ld_o), .ld_v(ld_v),
      .br_p_o(br_p_o), .br_psel(br_psel), .rp_o(rp_o), .ovf(ovf), .udf(udf));

   ej32_rsbr #(.DSZ(32), .ASZ(17), .DEPTH(64), .REL(0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .rs_cmd(rs_cmd), .rs_d(rs_d), .rs_idx(rs_idx),
      .br_cmd(br_cmd), .br_cond(br_cond), .phase(phase), .data(data), .p(p),
      .flag_clr(flag_clr), .r_o(r_o0), .rz_o(rz_o0), .ld_o(ld_o0), .ld_v(ld_v0),
      .br_p_o(br_p_o0), .br_psel(br_psel0), .rp_o(rp_o0), .ovf(ovf0), .udf(udf0));

   // Clock and reset
   always #5 clk = ~clk;

   // Comparison point
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rs_cmd = 3'd0; br_cmd = 2'd0; br_cond = 1'b0; phase = 1'b0;
      flag_clr = 1'b0; rs_idx = 8'd0; data = 8'd0;
   endtask

   task automatic rs_op(input logic [2:0] cmd, input logic [31:0] d, input logic [7:0] idx);
      rs_cmd = cmd; rs_d = d; rs_idx = idx;
      tick();
      rs_cmd = 3'd0;
   endtask

   task automatic br_byte(input logic [1:0] bc, input logic cond, input logic ph, input logic [7:0] b);
      br_cmd = bc; br_cond = cond; phase = ph; data = b;
      tick();
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; rs_d = '0; p = '0;
      idle();
      // Reset state
      tick(); tick();
      chk("rst_r", r_o, 0);       chk("rst_rz", rz_o, 1);
      chk("rst_rp", rp_o, 0);     chk("rst_ovf", ovf, 0);
      chk("rst_udf", udf, 0);     chk("rst_psel", br_psel, 0);
      chk("rst_brp", br_p_o, 0);  chk("rst_ldv", ld_v, 0);
      chk("rst_ldo", ld_o, 0);
      rst = 1'b1; en = 1'b1;
      tick();

      // Push three, load deepest, pop all
      rs_op(3'd1, 32'h11, 0); rs_op(3'd1, 32'h22, 0); rs_op(3'd1, 32'h33, 0);
      chk("push3_r", r_o, 32'h33); chk("push3_rp", rp_o, 3); chk("push3_rz", rz_o, 0);
      rs_op(3'd4, 0, 8'd2);
      chk("load2_ld", ld_o, 32'h11); chk("load2_v", ld_v, 1);
      tick();
      chk("load2_vdrop", ld_v, 0);
      rs_op(3'd4, 0, 8'd0);
      chk("load0_ld", ld_o, 32'h33);
      rs_op(3'd2, 0, 0);
      chk("pop1_r", r_o, 32'h22); chk("pop1_rp", rp_o, 2);
      rs_op(3'd2, 0, 0);
      chk("pop2_r", r_o, 32'h11);
      rs_op(3'd2, 0, 0);
      chk("pop3_r", r_o, 0); chk("pop3_rp", rp_o, 0); chk("pop3_rz", rz_o, 1); chk("pop3_udf", udf, 0);

      // Fill to DEPTH, overflow, deepest load, drain, underflow, clear
      for (int i = 1; i <= 64; i++) rs_op(3'd1, 32'(i), 0);
      chk("full_rp", rp_o, 64); chk("full_r", r_o, 64); chk("full_ovf0", ovf, 0);
      rs_op(3'd1, 32'hDEAD, 0);
      chk("ovf_flag", ovf, 1); chk("ovf_rp", rp_o, 64); chk("ovf_r", r_o, 64);
      rs_op(3'd4, 0, 8'd63);
      chk("load63", ld_o, 1); chk("load63_udf", udf, 0);
      rs_op(3'd4, 0, 8'd64);
      chk("load64_ld", ld_o, 0); chk("load64_v", ld_v, 1); chk("load64_udf", udf, 1);
      flag_clr = 1'b1; tick(); flag_clr = 1'b0;
      chk("clr_ovf", ovf, 0); chk("clr_udf", udf, 0);
      for (int i = 0; i < 63; i++) rs_op(3'd2, 0, 0);
      chk("drain63_r", r_o, 1); chk("drain63_rp", rp_o, 1);
      rs_op(3'd2, 0, 0);
      chk("drain_rp", rp_o, 0); chk("drain_udf", udf, 0);
      rs_op(3'd2, 0, 0);
      chk("udf_pop", udf, 1); chk("udf_rp", rp_o, 0);
      rs_op(3'd3, 32'h9, 0);
      chk("move_empty_r", r_o, 0);
      // Clear and new error in the same cycle: error wins
      flag_clr = 1'b1; rs_op(3'd2, 0, 0); flag_clr = 1'b0;
      chk("clr_vs_err", udf, 1);
      flag_clr = 1'b1; tick(); flag_clr = 1'b0;
      chk("clr2_udf", udf, 0);

      // Move on a live stack
      rs_op(3'd1, 32'h7, 0);
      rs_op(3'd3, 32'h9, 0);
      chk("move_r", r_o, 32'h9); chk("move_rp", rp_o, 1);
      rs_op(3'd2, 0, 0);

      // Unconditional, relative offset -4 from 0x100
      p = 17'h00100;
      br_byte(2'd2, 0, 0, 8'hFF);
      chk("uc_ph0_psel", br_psel, 0);
      br_byte(2'd2, 0, 1, 8'hFC);
      chk("uc_rel_brp", br_p_o, 17'h000FC); chk("uc_psel", br_psel, 1);
      chk("uc_abs_brp", br_p_o0, 17'h0FFFC);
      br_byte(2'd0, 0, 0, 8'h00);
      chk("uc_psel_drop", br_psel, 0);

      // Absolute bytes 0x12,0x34
      br_byte(2'd2, 0, 0, 8'h12);
      br_byte(2'd2, 0, 1, 8'h34);
      chk("abs_brp", br_p_o0, 17'h01234); chk("abs_rel_brp", br_p_o, 17'h01334);
      idle(); tick();

      // Conditional not taken, then taken
      br_byte(2'd1, 0, 0, 8'h00);
      br_byte(2'd1, 0, 1, 8'h10);
      chk("cnd0_psel", br_psel, 0); chk("cnd0_brp", br_p_o, 17'h01334);
      br_byte(2'd1, 1, 0, 8'h00);
      br_byte(2'd1, 1, 1, 8'h10);
      chk("cnd1_psel", br_psel, 1); chk("cnd1_brp", br_p_o, 17'h00110);
      idle(); tick();

      // Relative target wraps modulo 2^17
      p = 17'h1FFFF;
      br_byte(2'd2, 0, 0, 8'h00);
      br_byte(2'd2, 0, 1, 8'h02);
      chk("wrap_brp", br_p_o, 17'h00001);
      idle(); tick();

      // NEXT loop: counter 2, offset -8 from 0x200
      p = 17'h00200;
      rs_op(3'd1, 32'd2, 0);
      rs_cmd = 3'd5; br_byte(2'd0, 0, 0, 8'hFF);
      chk("nx_ph0_r", r_o, 2); chk("nx_ph0_psel", br_psel, 0);
      br_byte(2'd0, 0, 1, 8'hF8);
      chk("nx1_r", r_o, 1); chk("nx1_psel", br_psel, 1); chk("nx1_brp", br_p_o, 17'h001F8);
      br_byte(2'd0, 0, 0, 8'hFF);
      br_byte(2'd0, 0, 1, 8'hF8);
      chk("nx2_r", r_o, 0); chk("nx2_psel", br_psel, 1); chk("nx2_rz", rz_o, 1);
      br_byte(2'd2, 0, 0, 8'h00);
      br_byte(2'd2, 0, 1, 8'h40);
      chk("nx3_psel", br_psel, 0); chk("nx3_rp", rp_o, 0); chk("nx3_brp", br_p_o, 17'h001F8);
      br_byte(2'd0, 0, 1, 8'h40);
      chk("nx_empty_udf", udf, 1); chk("nx_empty_psel", br_psel, 0);
      idle(); flag_clr = 1'b1; tick(); flag_clr = 1'b0;

      // Async reset mid-branch drops the pending high byte
      rs_op(3'd1, 32'h55, 0);
      p = 17'h00300;
      br_byte(2'd2, 0, 0, 8'hAB);
      #2 rst = 1'b0;
      #1;
      chk("arst_r", r_o, 0); chk("arst_rp", rp_o, 0); chk("arst_brp", br_p_o, 0); chk("arst_rz", rz_o, 1);
      idle(); tick();
      rst = 1'b1;
      br_byte(2'd2, 0, 1, 8'h20);
      chk("arst_hi0_brp", br_p_o, 17'h00320); chk("arst_hi0_psel", br_psel, 1);
      idle(); tick();

      // Disabled cycles freeze state and drop strobes
      en = 1'b0;
      rs_op(3'd1, 32'h99, 0);
      chk("en0_rp", rp_o, 0); chk("en0_r", r_o, 0);
      br_byte(2'd2, 0, 1, 8'h11);
      chk("en0_psel", br_psel, 0); chk("en0_brp", br_p_o, 17'h00320);
      en = 1'b1; idle(); tick();

      // Concurrent push with branch phase 0 and resolve
      p = 17'h00040;
      rs_cmd = 3'd1; rs_d = 32'hABC; br_byte(2'd2, 0, 0, 8'h00);
      rs_cmd = 3'd0; br_byte(2'd2, 0, 1, 8'h08);
      chk("cc_r", r_o, 32'hABC); chk("cc_rp", rp_o, 1); chk("cc_brp", br_p_o, 17'h00048);
      idle(); tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
